// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the execute stage and the iterative multiply/divide unit.
// The core drives operands and takes results through the master side; the unit uses
// the slave side. WIDTH must match the unit's WIDTH.
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, div_by_zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One radix-2 step per cycle: shift-add for the
// multiplies, restoring shift-subtract for the divides. Operands are converted to
// magnitudes up front and the sign is re-applied at the end, so the iteration itself
// is purely unsigned. Latency is fixed at WIDTH+2 cycles from accept to out_valid.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               neg_q;
  logic               a_neg_q;
  logic               dbz_q;

  logic               in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               div_by_zero;

  logic               signed_a;
  logic               signed_b;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic [WIDTH-1:0]   fix_result;

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.result      = result;
  assign bus.zero        = zero;
  assign bus.div_by_zero = div_by_zero;

  // Operand signedness and magnitudes for the latched op (MULH, MULHSU-a, DIV, REM are signed)
  always_comb begin
    signed_a = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
    signed_b = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
    a_neg    = signed_a && a_q[WIDTH-1];
    b_neg    = signed_b && b_q[WIDTH-1];
    a_abs    = a_neg ? -a_q : a_q;
    b_abs    = b_neg ? -b_q : b_q;
  end

  // One iteration step: acc holds {hi, lo} for multiply and {remainder, quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    div_ok    = ~div_diff[WIDTH+1];
  end

  // Final sign fix-up and result selection; divide-by-zero bypasses the iterated value
  always_comb begin
    prod_fixed = neg_q ? -acc : acc;
    quot_fixed = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fixed  = a_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_result = '0;
    case (op_q)
      3'd0:             fix_result = prod_fixed[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: fix_result = prod_fixed[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       fix_result = dbz_q ? {WIDTH{1'b1}} : quot_fixed;
      default:          fix_result = dbz_q ? a_q : rem_fixed;
    endcase
  end

  // Control FSM with registered handshake outputs and the iterative datapath
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready) begin
            op_q     <= bus.op;
            a_q      <= bus.a;
            b_q      <= bus.b;
            in_ready <= 1'b0;
            state    <= PREP;
          end
        end
        PREP: begin
          neg_q   <= a_neg ^ b_neg;
          a_neg_q <= a_neg;
          dbz_q   <= op_q[2] && (b_q == '0);
          acc     <= {{WIDTH{1'b0}}, a_abs};
          opnd    <= b_abs;
          count   <= CW'(WIDTH - 1);
          state   <= ITER;
        end
        ITER: begin
          if (op_q[2]) begin
            if (div_ok) begin
              acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
              acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          if (count == '0) begin
            state <= FIX;
          end else begin
            count <= count - 1'b1;
          end
        end
        FIX: begin
          result      <= fix_result;
          zero        <= (fix_result == '0);
          div_by_zero <= dbz_q;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks for muldiv_unit at WIDTH=32: reset state, every op,
// divide-by-zero and signed-overflow corners, fixed latency, output hold under
// backpressure, and abort via flush and rst.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  logic flush;
  int   vectors;
  int   miscompares;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint     sa;
    longint     sb;
    longint     ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    p  = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, check latency and outputs, then complete the output handshake
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res,
                               input logic exp_zero, input logic exp_dbz);
    int cycles;
    @(negedge clk);
    checkOutput({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom);
    bus.a        = $urandom;
    bus.b        = $urandom;
    checkOutput({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
    cycles = 0;
    while (!bus.out_valid && cycles < 60) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput({tag, " latency"}, 32'(cycles), 32'd34);
    checkOutput({tag, " result"}, bus.result, exp_res);
    checkOutput({tag, " zero"}, 32'(bus.zero), 32'(exp_zero));
    checkOutput({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(exp_dbz));
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, " in_ready back"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Start a long op, abort it mid-iteration with flush or rst, and confirm recovery
  task automatic abortOp(input bit use_rst);
    string tag;
    tag = use_rst ? "rst abort" : "flush abort";
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 3'd5;
    bus.a        = 32'd1000;
    bus.b        = 32'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = 3'd0;
    bus.a        = 32'd9;
    bus.b        = 32'd9;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, " result"}, bus.result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, " dropped op"}, 32'(bus.in_ready), 32'd1);
    applyStimulus({tag, " MUL 5*5"}, 3'd0, 32'd5, 32'd5, 32'd25, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rexp;
    int          cycles;

    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = 3'd0;
    bus.a         = '0;
    bus.b         = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset result", bus.result, 32'd0);
    checkOutput("reset zero", 32'(bus.zero), 32'd0);
    checkOutput("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] multiply ops");
    applyStimulus("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);
    applyStimulus("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
    applyStimulus("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    applyStimulus("MULHSU -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);

    $display("[TB] divide ops");
    applyStimulus("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
    applyStimulus("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus("DIVU 7/2", 3'd5, 32'd7, 32'd2, 32'd3, 1'b0, 1'b0);
    applyStimulus("REMU 7/2", 3'd7, 32'd7, 32'd2, 32'd1, 1'b0, 1'b0);

    $display("[TB] divide corners");
    applyStimulus("DIVU 7/0", 3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    applyStimulus("REMU 7/0", 3'd7, 32'd7, 32'd0, 32'd7, 1'b0, 1'b1);
    applyStimulus("DIV -7/0", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    applyStimulus("REM -7/0", 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0, 1'b1);
    applyStimulus("DIV min/-1", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
    applyStimulus("REM min/-1", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    applyStimulus("REM 4/2", 3'd6, 32'd4, 32'd2, 32'd0, 1'b1, 1'b0);

    $display("[TB] backpressure hold");
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 3'd5;
    bus.a        = 32'd100;
    bus.b        = 32'd7;
    @(posedge clk);
    #1;
    bus.op = 3'd0;
    bus.a  = 32'd2;
    bus.b  = 32'd3;
    cycles = 0;
    while (!bus.out_valid && cycles < 60) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("hold latency", 32'(cycles), 32'd34);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold result", bus.result, 32'd14);
      checkOutput("hold out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("handshake in_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus("MUL 3*4 after hold", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);

    $display("[TB] abort");
    abortOp(1'b0);
    abortOp(1'b1);

    $display("[TB] random ops");
    for (int i = 0; i < 1000; i++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = pickOperand();
      rb   = pickOperand();
      rexp = model(rop, ra, rb);
      applyStimulus($sformatf("rand op%0d 0x%08h,0x%08h", rop, ra, rb), rop, ra, rb, rexp,
                    rexp == 32'd0, rop[2] && rb == 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
